// File: rtl/hnf_sram_mask_ctl_if.sv
// Requester-side bus of the HN-F masked data SRAM controller: one write
// (fill) channel, one read (drain) channel, the read-data return path and
// the init-done indication.
interface hnf_sram_mask_ctl_if #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 512,
  parameter int RAM_MASK_WIDTH = 16,
  parameter int ID_WIDTH       = 8
);
  localparam int ENTRY_WIDTH = RAM_DATA_WIDTH * RAM_MASK_WIDTH;

  // Write request channel
  logic                      wr_valid;
  logic                      wr_ready;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_MASK_WIDTH-1:0] wr_mask;
  logic [RAM_DATA_WIDTH-1:0] wr_data;

  // Read request channel
  logic                      rd_valid;
  logic                      rd_ready;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  logic [ID_WIDTH-1:0]       rd_id;

  // Read data return (no backpressure) and status
  logic                      rd_data_valid;
  logic [ENTRY_WIDTH-1:0]    rd_data;
  logic [ID_WIDTH-1:0]       rd_rsp_id;
  logic                      init_done;

  modport master (
    output wr_valid, wr_addr, wr_mask, wr_data,
    output rd_valid, rd_addr, rd_id,
    input  wr_ready, rd_ready,
    input  rd_data_valid, rd_data, rd_rsp_id, init_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_mask, wr_data,
    input  rd_valid, rd_addr, rd_id,
    output wr_ready, rd_ready,
    output rd_data_valid, rd_data, rd_rsp_id, init_done
  );
endinterface

// File: rtl/hnf_sram_mask_ctl.sv
// Sequencing and arbitration controller for the HN-F masked data SRAM.
// After reset it clears every entry, then shares the single SRAM port
// between a write requester and a read requester with a one-bit
// round-robin, returning read data RD_LAT+2 cycles after the handshake.
// RD_LAT selects the SRAM macro read latency and must be 0 or 1.
module hnf_sram_mask_ctl #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 512,
  parameter int RAM_MASK_WIDTH = 16,
  parameter int RD_LAT         = 0,
  parameter int ID_WIDTH       = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  hnf_sram_mask_ctl_if.slave                       req,
  output logic                                     sram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0]                sram_addr_o,
  output logic [RAM_MASK_WIDTH-1:0]                sram_wmask_o,
  output logic [RAM_DATA_WIDTH-1:0]                sram_data_o,
  input  logic [RAM_DATA_WIDTH*RAM_MASK_WIDTH-1:0] sram_data_i
);

  localparam int ENTRY_WIDTH = RAM_DATA_WIDTH * RAM_MASK_WIDTH;
  // One extra bit so the sweep counter can express "all DEPTH entries issued".
  localparam int CNT_WIDTH   = RAM_ADDR_WIDTH + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      sweep_q, sweep_d;
  logic                      last_rd_q, last_rd_d;   // 1: last grant went to the read side
  logic                      wr_gnt, rd_gnt;

  logic                      sram_we_q, sram_we_d;
  logic [RAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [RAM_MASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
  logic [RAM_DATA_WIDTH-1:0] sram_data_q, sram_data_d;

  logic [RD_LAT:0]           pipe_vld_q;
  logic [ID_WIDTH-1:0]       pipe_id_q [RD_LAT+1];
  logic                      rd_vld_q;
  logic [ENTRY_WIDTH-1:0]    rd_data_q;
  logic [ID_WIDTH-1:0]       rd_id_q;

  // Round-robin grant: a lone requester wins; on contention the side not granted last wins.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (state_q == ST_RUN) begin
      if (req.wr_valid && (!req.rd_valid || last_rd_q)) begin
        wr_gnt = 1'b1;
      end else if (req.rd_valid) begin
        rd_gnt = 1'b1;
      end
    end
  end

  assign req.wr_ready = wr_gnt;
  assign req.rd_ready = rd_gnt;

  // Next state, sweep counter, round-robin pointer and SRAM pin values for the next cycle.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    last_rd_d    = last_rd_q;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wmask_d = '0;
    sram_data_d  = sram_data_q;
    case (state_q)
      ST_INIT: begin
        if (!sweep_q[RAM_ADDR_WIDTH]) begin
          sram_we_d    = 1'b1;
          sram_addr_d  = sweep_q[RAM_ADDR_WIDTH-1:0];
          sram_wmask_d = '1;
          sram_data_d  = '0;
          sweep_d      = sweep_q + CNT_WIDTH'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wr_gnt) begin
          sram_we_d    = 1'b1;
          sram_addr_d  = req.wr_addr;
          sram_wmask_d = req.wr_mask;
          sram_data_d  = req.wr_data;
          last_rd_d    = 1'b0;
        end else if (rd_gnt) begin
          sram_addr_d  = req.rd_addr;
          last_rd_d    = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control state and registered SRAM pins.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      last_rd_q    <= 1'b1;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wmask_q <= '0;
      sram_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      last_rd_q    <= last_rd_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wmask_q <= sram_wmask_d;
      sram_data_q  <= sram_data_d;
    end
  end

  // Read tag pipeline; stage RD_LAT lines up with valid SRAM read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_id_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_gnt;
      pipe_id_q[0]  <= req.rd_id;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  // Read return register: captures the SRAM entry and tag when the matching stage is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_id_q   <= '0;
    end else begin
      rd_vld_q <= pipe_vld_q[RD_LAT];
      if (pipe_vld_q[RD_LAT]) begin
        rd_data_q <= sram_data_i;
        rd_id_q   <= pipe_id_q[RD_LAT];
      end
    end
  end

  assign req.rd_data_valid = rd_vld_q;
  assign req.rd_data       = rd_data_q;
  assign req.rd_rsp_id     = rd_id_q;
  assign req.init_done     = (state_q == ST_RUN);

  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wmask_o = sram_wmask_q;
  assign sram_data_o  = sram_data_q;

endmodule
